// File: rtl/keymgr_out_gate_if.sv
// Handshake bundle between the key manager op sequencer and the output gate.
interface keymgr_out_gate_if #(
  parameter int unsigned ERR_W = 3
);
  logic             op_start;
  logic [2:0]       op;
  logic             op_done;
  logic [9:0]       ctrl_state;
  logic             sw_rd_ack;
  logic             hw_ack;
  logic             data_hw_en;
  logic             data_sw_en;
  logic             data_valid;
  logic             op_invalid;
  logic [ERR_W-1:0] err_cnt;
  logic             locked;

  modport master (
    output op_start, op, op_done, ctrl_state, sw_rd_ack, hw_ack,
    input  data_hw_en, data_sw_en, data_valid, op_invalid, err_cnt, locked
  );

  modport slave (
    input  op_start, op, op_done, ctrl_state, sw_rd_ack, hw_ack,
    output data_hw_en, data_sw_en, data_valid, op_invalid, err_cnt, locked
  );
endinterface

// File: rtl/keymgr_out_gate.sv
// Access-control gate: key output enables driven only from ctrl state and op legality.
module keymgr_out_gate #(
  parameter int unsigned SW_TIMEOUT = 16,
  parameter int unsigned MAX_ERR    = 4,
  parameter int unsigned ERR_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  keymgr_out_gate_if.slave bus
);

  localparam int unsigned      TW             = $clog2(SW_TIMEOUT);
  localparam logic [9:0]       CTRL_OWNER_KEY = 10'b1101111110;
  localparam logic [TW-1:0]    TIMER_LAST     = TW'(SW_TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_LIMIT      = ERR_W'(MAX_ERR);

  typedef enum logic [2:0] {
    OP_ADVANCE    = 3'd0,
    OP_GEN_ID     = 3'd1,
    OP_GEN_SW_OUT = 3'd2,
    OP_GEN_HW_OUT = 3'd3,
    OP_DISABLE    = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY,
    ST_GRANT_HW,
    ST_GRANT_SW,
    ST_LOCKED
  } state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             owner_q, owner_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             hw_en_q, hw_en_d;
  logic             sw_en_q, sw_en_d;
  logic             valid_q, valid_d;
  logic             invalid_q, invalid_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;

  logic             owner_live;
  logic             illegal;
  logic [ERR_W-1:0] err_inc;

  assign owner_live = (bus.ctrl_state == CTRL_OWNER_KEY);

  // Next-state, op evaluation and registered output values.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    owner_d   = owner_q;
    timer_d   = '0;
    invalid_d = 1'b0;
    err_cnt_d = err_cnt_q;
    illegal   = 1'b0;
    err_inc   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.op_start) begin
          state_d = ST_BUSY;
          op_d    = op_e'(bus.op);
          owner_d = owner_live;
        end
      end

      ST_BUSY: begin
        if (!bus.op_start) begin
          state_d = ST_IDLE;
        end else if (bus.op_done) begin
          state_d = ST_IDLE;
          case (op_q)
            OP_ADVANCE: ;
            OP_DISABLE: state_d = ST_LOCKED;
            OP_GEN_ID, OP_GEN_SW_OUT, OP_GEN_HW_OUT: begin
              // Legality follows the latched state; the grant is only taken if the
              // live state still matches, so an enable never follows a non-owner cycle.
              if (!owner_q) begin
                illegal = 1'b1;
              end else if (owner_live) begin
                state_d = (op_q == OP_GEN_HW_OUT) ? ST_GRANT_HW : ST_GRANT_SW;
              end
            end
            default: illegal = 1'b1;
          endcase

          if (illegal) begin
            invalid_d = 1'b1;
            err_cnt_d = err_inc;
            if (err_inc >= ERR_LIMIT) begin
              state_d = ST_LOCKED;
            end
          end
        end
      end

      ST_GRANT_HW: begin
        if (!owner_live || bus.hw_ack) begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT_SW: begin
        if (!owner_live || bus.sw_rd_ack || (timer_q == TIMER_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_LOCKED: ;

      default: state_d = ST_IDLE;
    endcase

    hw_en_d  = (state_d == ST_GRANT_HW);
    sw_en_d  = (state_d == ST_GRANT_SW);
    valid_d  = hw_en_d | sw_en_d;
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADVANCE;
      owner_q   <= 1'b0;
      timer_q   <= '0;
      hw_en_q   <= 1'b0;
      sw_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      hw_en_q   <= hw_en_d;
      sw_en_q   <= sw_en_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.data_hw_en = hw_en_q;
  assign bus.data_sw_en = sw_en_q;
  assign bus.data_valid = valid_q;
  assign bus.op_invalid = invalid_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_keymgr_out_gate.sv
// Bench for keymgr_out_gate: vector table, directed corner cases, randomized run vs model.
module tb_keymgr_out_gate;
  localparam int unsigned SW_TIMEOUT = 16;
  localparam int unsigned MAX_ERR    = 4;
  localparam int unsigned ERR_W      = 3;
  localparam logic [9:0]  OK = 10'b1101111110;
  localparam logic [9:0]  RS = 10'b1101100001;
  localparam logic [9:0]  IN = 10'b0100000100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keymgr_out_gate_if #(.ERR_W(ERR_W)) bus_if ();

  keymgr_out_gate #(
    .SW_TIMEOUT(SW_TIMEOUT),
    .MAX_ERR   (MAX_ERR),
    .ERR_W     (ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference model: transaction view of the gate.
  bit m_busy, m_locked, m_inv, m_owner_at_start;
  int m_grant;  // 0 none, 1 hw, 2 sw
  int m_age, m_err, m_op;

  function automatic void model_clock(bit r, bit s, bit [2:0] o, bit d, bit [9:0] st, bit sa, bit ha);
    bit owner;
    bit finish;
    owner = (st == OK);
    m_inv = 1'b0;
    if (r) begin
      m_busy = 0; m_locked = 0; m_grant = 0; m_age = 0; m_err = 0;
      return;
    end
    if (m_locked) return;
    if (m_grant != 0) begin
      if (m_grant == 1) finish = !owner || ha;
      else              finish = !owner || sa || (m_age >= int'(SW_TIMEOUT) - 1);
      if (finish) m_grant = 0;
      else        m_age++;
    end else if (m_busy) begin
      if (!s) begin
        m_busy = 0;
      end else if (d) begin
        m_busy = 0;
        if (m_op == 4) begin
          m_locked = 1;
        end else if (m_op == 0) begin
          // advance: nothing granted
        end else if (m_op <= 3 && m_owner_at_start) begin
          if (owner) begin
            m_grant = (m_op == 3) ? 1 : 2;
            m_age   = 0;
          end
        end else begin
          m_inv = 1;
          if (m_err < (1 << ERR_W) - 1) m_err++;
          if (m_err >= int'(MAX_ERR)) m_locked = 1;
        end
      end
    end else if (s) begin
      m_busy = 1;
      m_op = int'(o);
      m_owner_at_start = owner;
    end
  endfunction

  task automatic drive(bit r, bit s, bit [2:0] o, bit d, bit [9:0] st, bit sa, bit ha);
    rst               = r;
    bus_if.op_start   = s;
    bus_if.op         = o;
    bus_if.op_done    = d;
    bus_if.ctrl_state = st;
    bus_if.sw_rd_ack  = sa;
    bus_if.hw_ack     = ha;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock(rst, bus_if.op_start, bus_if.op, bus_if.op_done, bus_if.ctrl_state,
                bus_if.sw_rd_ack, bus_if.hw_ack);
    #1;
  endtask

  task automatic run_op(bit [2:0] o, bit [9:0] st);
    drive(0, 1, o, 0, st, 0, 0); tick();
    drive(0, 1, o, 1, st, 0, 0); tick();
    drive(0, 0, 0, 0, st, 0, 0);
  endtask

  function automatic void check_model(string tag);
    chk({tag, ".hw"},    bus_if.data_hw_en, m_grant == 1);
    chk({tag, ".sw"},    bus_if.data_sw_en, m_grant == 2);
    chk({tag, ".valid"}, bus_if.data_valid, m_grant != 0);
    chk({tag, ".inv"},   bus_if.op_invalid, m_inv);
    chk({tag, ".err"},   bus_if.err_cnt,    m_err);
    chk({tag, ".lock"},  bus_if.locked,     m_locked);
  endfunction

  // Invariants in the registered view, checked every cycle.
  bit inv_on = 1'b0;
  bit prev_owner;
  always @(posedge clk) prev_owner <= (bus_if.ctrl_state == OK);
  always @(negedge clk) begin
    if (inv_on) begin
      chk("inv_exclusive", bus_if.data_hw_en & bus_if.data_sw_en, 0);
      chk("inv_owner_gate", (bus_if.data_hw_en | bus_if.data_sw_en) & ~prev_owner, 0);
    end
  end

  typedef struct {
    bit r, s; bit [2:0] op; bit d; bit [9:0] st; bit sa, ha;
    bit e_hw, e_sw, e_inv; int e_err; bit e_lk;
  } vec_t;

  vec_t vecs[$];
  int   cnt;

  initial begin
    drive(1, 0, 0, 0, OK, 0, 0);

    //            r s op d st sa ha  hw sw inv err lk
    vecs.push_back('{1,0,0,0,OK,0,0, 0,0,0,0,0});  // reset
    vecs.push_back('{0,1,3,0,OK,0,0, 0,0,0,0,0});  // GenHwOut busy
    vecs.push_back('{0,1,3,1,OK,0,0, 1,0,0,0,0});  // done at t -> hw at t+1
    vecs.push_back('{0,1,2,0,OK,0,0, 1,0,0,0,0});  // new start ignored
    vecs.push_back('{0,1,2,1,OK,0,0, 1,0,0,0,0});  // ignored done
    vecs.push_back('{0,0,0,0,OK,0,1, 0,0,0,0,0});  // hw_ack at t+3 -> off at t+4
    vecs.push_back('{0,1,0,0,RS,0,0, 0,0,0,0,0});  // Advance in Reset
    vecs.push_back('{0,1,0,1,RS,0,0, 0,0,0,0,0});
    vecs.push_back('{0,1,1,0,RS,0,0, 0,0,0,0,0});  // GenId in Reset
    vecs.push_back('{0,1,1,1,RS,0,0, 0,0,1,1,0});
    vecs.push_back('{0,1,2,0,RS,0,0, 0,0,0,1,0});  // GenSwOut in Reset
    vecs.push_back('{0,1,2,1,RS,0,0, 0,0,1,2,0});
    vecs.push_back('{0,1,3,0,RS,0,0, 0,0,0,2,0});  // GenHwOut in Reset
    vecs.push_back('{0,1,3,1,RS,0,0, 0,0,1,3,0});
    vecs.push_back('{0,1,5,0,RS,0,0, 0,0,0,3,0});  // busy then start drops
    vecs.push_back('{0,0,0,0,RS,0,0, 0,0,0,3,0});  // no error counted
    vecs.push_back('{0,1,7,0,OK,0,0, 0,0,0,3,0});  // op 7 illegal anywhere
    vecs.push_back('{0,1,7,1,OK,0,0, 0,0,1,4,1});  // fourth error locks
    vecs.push_back('{0,1,3,0,OK,0,0, 0,0,0,4,1});
    vecs.push_back('{0,1,3,1,OK,0,0, 0,0,0,4,1});  // legal op ignored when locked
    vecs.push_back('{0,1,6,1,OK,0,0, 0,0,0,4,1});  // err frozen
    vecs.push_back('{1,0,0,0,OK,0,0, 0,0,0,0,0});  // reset clears lock

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].op, vecs[i].d, vecs[i].st, vecs[i].sa, vecs[i].ha);
      tick();
      if (i == 0) inv_on = 1'b1;
      chk($sformatf("vec%0d.hw", i),    bus_if.data_hw_en, vecs[i].e_hw);
      chk($sformatf("vec%0d.sw", i),    bus_if.data_sw_en, vecs[i].e_sw);
      chk($sformatf("vec%0d.valid", i), bus_if.data_valid, vecs[i].e_hw | vecs[i].e_sw);
      chk($sformatf("vec%0d.inv", i),   bus_if.op_invalid, vecs[i].e_inv);
      chk($sformatf("vec%0d.err", i),   bus_if.err_cnt,    vecs[i].e_err);
      chk($sformatf("vec%0d.lock", i),  bus_if.locked,     vecs[i].e_lk);
    end

    // Software grant with no ack: held exactly SW_TIMEOUT cycles.
    run_op(2, OK);
    chk("swto.rise", bus_if.data_sw_en, 1);
    chk("swto.hw",   bus_if.data_hw_en, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.data_sw_en) cnt++;
      tick();
    end
    chk("swto.cycles", cnt, 16);
    chk("swto.off", bus_if.data_sw_en, 0);

    // Ack coinciding with the last timer cycle.
    run_op(2, OK);
    repeat (15) tick();
    chk("swack_last.hold", bus_if.data_sw_en, 1);
    drive(0, 0, 0, 0, OK, 1, 0); tick();
    chk("swack_last.off", bus_if.data_sw_en, 0);
    drive(0, 0, 0, 0, OK, 0, 0); tick();
    chk("swack_last.idle", bus_if.data_valid, 0);

    // Early software ack.
    run_op(1, OK);
    tick();
    drive(0, 0, 0, 0, OK, 1, 0); tick();
    chk("swack_early.off", bus_if.data_sw_en, 0);
    chk("swack_early.inv", bus_if.op_invalid, 0);

    // Ctrl state leaves OwnerKey mid-hold.
    run_op(1, OK);
    repeat (3) tick();
    chk("stdrop.hold", bus_if.data_sw_en, 1);
    drive(0, 0, 0, 0, IN, 1, 0); tick();
    chk("stdrop.sw",    bus_if.data_sw_en, 0);
    chk("stdrop.valid", bus_if.data_valid, 0);
    run_op(1, IN);
    chk("init_gen.inv", bus_if.op_invalid, 1);
    chk("init_gen.err", bus_if.err_cnt, 1);

    // Reset while busy.
    drive(0, 1, 3, 0, IN, 0, 0); tick();
    drive(1, 1, 3, 1, IN, 0, 0); tick();
    chk("rstbusy.hw",    bus_if.data_hw_en, 0);
    chk("rstbusy.sw",    bus_if.data_sw_en, 0);
    chk("rstbusy.valid", bus_if.data_valid, 0);
    chk("rstbusy.inv",   bus_if.op_invalid, 0);
    chk("rstbusy.err",   bus_if.err_cnt, 0);
    chk("rstbusy.lock",  bus_if.locked, 0);

    // Reset aborts a hardware grant.
    run_op(3, OK);
    chk("rstgrant.on", bus_if.data_hw_en, 1);
    drive(1, 0, 0, 0, OK, 0, 0); tick();
    chk("rstgrant.hw",    bus_if.data_hw_en, 0);
    chk("rstgrant.valid", bus_if.data_valid, 0);

    // OpDisable locks without touching err_cnt.
    run_op(5, OK);
    chk("dis.pre_err", bus_if.err_cnt, 1);
    run_op(4, OK);
    chk("dis.lock", bus_if.locked, 1);
    chk("dis.err",  bus_if.err_cnt, 1);
    chk("dis.inv",  bus_if.op_invalid, 0);
    run_op(3, OK);
    tick();
    chk("dis.hw_blocked", bus_if.data_hw_en, 0);
    chk("dis.still_lock", bus_if.locked, 1);

    // Randomized run against the model.
    drive(1, 0, 0, 0, OK, 0, 0); tick(); tick();
    check_model("rnd_reset");
    begin
      logic [9:0] st;
      bit r, s, d, sa, ha;
      bit [2:0] o;
      st = OK;
      for (int c = 0; c < 4000; c++) begin
        r  = ($urandom_range(0, 199) == 0) || (m_locked && $urandom_range(0, 15) == 0);
        s  = ($urandom_range(0, 9) < 7);
        o  = ($urandom_range(0, 99) < 85) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        d  = ($urandom_range(0, 3) == 0);
        sa = ($urandom_range(0, 23) == 0);
        ha = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 5))
            0:       st = RS;
            1:       st = IN;
            2:       st = 10'($urandom());
            default: st = OK;
          endcase
        end
        drive(r, s, o, d, st, sa, ha);
        tick();
        check_model($sformatf("rnd%0d", c));
      end
    end

    inv_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
